// File: rtl/word_to_bit_serializer.sv
// Word-to-bit serializer: a small FIFO of DATA_W-bit words drained by a shifter that emits
// one bit per clock on bit_out, back-to-back across words, with a halt that freezes the read side.
module word_to_bit_serializer #(
    parameter int   DATA_W     = 8,
    parameter int   FIFO_DEPTH = 4,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    input  logic                              halt,
    output logic                              bit_out,
    output logic                              bit_valid,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W+1);
    localparam int IW = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [BW-1:0]       bitcnt, bitcnt_d;
    logic                bout_d, valid_q, vq_d;
    logic                push, pop, do_load;
    logic [DATA_W-1:0]   head;
    logic                first_bit;
    logic [IW-1:0]       nxt_idx;

    assign s_ready    = ~rst & (count != CW'(FIFO_DEPTH));
    assign push       = s_valid & s_ready;
    assign head       = mem[rd_ptr];
    assign first_bit  = (MSB_FIRST != 0) ? head[DATA_W-1] : head[0];
    assign bit_valid  = valid_q & ~halt;
    assign busy       = (state == SHIFT) | (count != '0);
    assign fifo_count = count;

    // bitcnt counts bits already driven, so it directly selects the next one
    always_comb begin
        if (MSB_FIRST != 0) nxt_idx = IW'(DATA_W - 1 - int'(bitcnt));
        else                nxt_idx = IW'(bitcnt);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        bout_d   = bit_out;
        vq_d     = valid_q;
        do_load  = 1'b0;
        if (!halt) begin
            case (state)
                IDLE: begin
                    if (count != '0) do_load = 1'b1;
                end
                SHIFT: begin
                    if (bitcnt != BW'(DATA_W)) begin
                        bout_d   = shreg[nxt_idx];
                        bitcnt_d = bitcnt + BW'(1);
                    end else if (count != '0) begin
                        do_load = 1'b1;
                    end else begin
                        bout_d  = IDLE_BIT;
                        vq_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (do_load) begin
            shreg_d  = head;
            bout_d   = first_bit;
            vq_d     = 1'b1;
            bitcnt_d = BW'(1);
            state_d  = SHIFT;
        end
        pop = do_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            bit_out <= IDLE_BIT;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bitcnt  <= bitcnt_d;
            bit_out <= bout_d;
            valid_q <= vq_d;
        end
    end
endmodule

// File: tb/tb_word_to_bit_serializer.sv
// Bench for word_to_bit_serializer: MSB-first and LSB-first instances share one stimulus,
// directed vector table, hand sequences for halt/reset corners, then random traffic vs a queue model.
module tb_word_to_bit_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       halt = 1'b0;
    logic       rdy0, bo0, bv0, busy0, rdy1, bo1, bv1, busy1;
    logic [2:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    word_to_bit_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data), .halt(halt),
        .bit_out(bo0), .bit_valid(bv0), .busy(busy0), .fifo_count(cnt0));
    word_to_bit_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data), .halt(halt),
        .bit_out(bo1), .bit_valid(bv1), .busy(busy1), .fifo_count(cnt1));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_msb;  // bits in time order, first bit in [7]
        logic [7:0] seq_lsb;
    } vec_t;

    // Push one word into an idle serializer and check latency, bit order and return to idle.
    task automatic run_word(input logic [7:0] d, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] q0, q1;
        logic       all0, all1;
        q0 = '0; q1 = '0; all0 = 1'b1; all1 = 1'b1;
        @(negedge clk); s_valid = 1'b1; s_data = d;
        @(negedge clk); s_valid = 1'b0;
        check("latency_bv", {31'd0, bv0}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            q0 = {q0[6:0], bo0}; q1 = {q1[6:0], bo1};
            all0 &= bv0; all1 &= bv1;
        end
        check("seq_msb", {24'd0, q0}, {24'd0, e0});
        check("seq_lsb", {24'd0, q1}, {24'd0, e1});
        check("valid_run", {30'd0, all0, all1}, 32'd3);
        @(negedge clk);
        check("end_bv", {30'd0, bv0, bv1}, 32'd0);
        check("end_bo", {30'd0, bo0, bo1}, 32'd0);
        check("end_busy", {30'd0, busy0, busy1}, 32'd0);
    endtask

    // Reference model: FIFO as a queue, current word as queues of bits still to be sent.
    int   fq[$];
    bit   bq0[$], bq1[$];
    bit   mvalid, mb0, mb1;

    task automatic model_step(input logic v, input logic [7:0] d, input logic h);
        bit do_push;
        int w;
        do_push = v && (fq.size() < 4);
        if (!h) begin
            if (mvalid && bq0.size() != 0) begin
                mb0 = bq0.pop_front(); mb1 = bq1.pop_front();
            end else if (fq.size() != 0) begin
                w = fq.pop_front();
                for (int k = 0; k < 8; k++) begin
                    bq0.push_back(w[7-k]);
                    bq1.push_back(w[k]);
                end
                mb0 = bq0.pop_front(); mb1 = bq1.pop_front(); mvalid = 1'b1;
            end else begin
                mvalid = 1'b0; mb0 = 1'b0; mb1 = 1'b0;
            end
        end
        if (do_push) fq.push_back(int'(d));
    endtask

    initial begin
        vec_t vt[5];
        logic [15:0] q16;
        logic [4:0]  q5;
        logic        ok;
        vt[0] = '{8'hA5, 8'hA5, 8'hA5};
        vt[1] = '{8'h01, 8'h01, 8'h80};
        vt[2] = '{8'h80, 8'h80, 8'h01};
        vt[3] = '{8'h3A, 8'h3A, 8'h5C};
        vt[4] = '{8'hF0, 8'hF0, 8'h0F};

        // reset state
        #12;
        check("rst_ready", {30'd0, rdy0, rdy1}, 32'd0);
        check("rst_bv", {30'd0, bv0, bv1}, 32'd0);
        check("rst_bo", {30'd0, bo0, bo1}, 32'd0);
        check("rst_busy", {30'd0, busy0, busy1}, 32'd0);
        check("rst_cnt", {29'd0, cnt0}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("rel_ready", {30'd0, rdy0, rdy1}, 32'd3);

        for (int i = 0; i < 5; i++) run_word(vt[i].data, vt[i].seq_msb, vt[i].seq_lsb);

        // back-to-back words, no bubble
        @(negedge clk); s_valid = 1'b1; s_data = 8'hFF;
        @(negedge clk); s_data = 8'h00;
        @(negedge clk); s_valid = 1'b0;
        q16 = '0; ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            q16 = {q16[14:0], bo0}; ok &= bv0 & bv1 & (bo0 == bo1);
        end
        check("b2b_seq", {16'd0, q16}, 32'h0000FF00);
        check("b2b_valid", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("b2b_end_bv", {31'd0, bv0}, 32'd0);

        // halt while filling: FIFO fills to depth, nothing pops
        halt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); s_valid = 1'b1; s_data = 8'(8'h10 + i);
        end
        @(negedge clk); s_valid = 1'b0;
        check("full_cnt", {29'd0, cnt0}, 32'd4);
        check("full_ready", {30'd0, rdy0, rdy1}, 32'd0);
        check("full_bv", {30'd0, bv0, bv1}, 32'd0);
        halt = 1'b0;
        @(negedge clk);
        check("pop_cnt", {29'd0, cnt0}, 32'd3);
        check("pop_ready", {31'd0, rdy0}, 32'd1);
        check("pop_bv", {31'd0, bv0}, 32'd1);
        check("pop_bit", {30'd0, bo0, bo1}, 32'd0);  // 0x10: msb-first 0, lsb-first 0
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1) ok = 1'b1;
        end
        check("drain_done", {31'd0, ok}, 32'd1);

        // halt mid-word for 3 cycles after the 3rd bit of 0xC3
        @(negedge clk); s_valid = 1'b1; s_data = 8'hC3;
        @(negedge clk); s_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre_halt_bit", {30'd0, bo0, bo1}, 32'd0);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_bv", {30'd0, bv0, bv1}, 32'd0);
            check("halt_bo", {30'd0, bo0, bo1}, 32'd0);
        end
        halt = 1'b0;
        q5 = '0; ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            q5 = {q5[3:0], bo0}; ok &= bv0 & bv1 & (bo0 == bo1);
        end
        check("resume_seq", {27'd0, q5}, 32'h3);
        check("resume_valid", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("resume_end", {30'd0, busy0, bv0}, 32'd0);

        // async reset in the middle of the 5th bit with 2 words queued
        @(negedge clk); s_valid = 1'b1; s_data = 8'h11;
        @(negedge clk); s_data = 8'h22;
        @(negedge clk); s_data = 8'h33;
        @(negedge clk); s_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre_rst_cnt", {29'd0, cnt0}, 32'd2);
        check("pre_rst_bv", {31'd0, bv0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_bv", {30'd0, bv0, bv1}, 32'd0);
        check("arst_bo", {30'd0, bo0, bo1}, 32'd0);
        check("arst_cnt", {26'd0, cnt0, cnt1}, 32'd0);
        check("arst_ready", {30'd0, rdy0, rdy1}, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_word(8'h80, 8'h80, 8'h01);

        // random traffic against the queue model
        fq.delete(); bq0.delete(); bq1.delete();
        mvalid = 1'b0; mb0 = 1'b0; mb1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("r_bv0", {31'd0, bv0}, {31'd0, mvalid & ~halt});
            check("r_bv1", {31'd0, bv1}, {31'd0, mvalid & ~halt});
            check("r_bo0", {31'd0, bo0}, {31'd0, mb0});
            check("r_bo1", {31'd0, bo1}, {31'd0, mb1});
            check("r_cnt", {26'd0, cnt0, cnt1}, {26'd0, 3'(fq.size()), 3'(fq.size())});
            check("r_ready", {30'd0, rdy0, rdy1}, (fq.size() < 4) ? 32'd3 : 32'd0);
            check("r_busy", {31'd0, busy0}, {31'd0, mvalid || (fq.size() != 0)});
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 8'($urandom);
            halt    = ($urandom_range(0, 7) == 0);
            model_step(s_valid, s_data, halt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
